// File: rtl/elastic_pipeline_register.sv
// DEPTH-stage elastic pipeline register: valid/ready flow control, clock enable,
// synchronous flush, bubble collapse and a registered occupancy count.
module elastic_pipeline_register #(
    parameter int N      = 8,
    parameter int DEPTH  = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, ready may depend combinationally on valid
    // and on downstream ready.
    logic [DEPTH-1:0] v_q;
    logic [N-1:0]     d_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [DEPTH-1:0] free;
    logic             in_xfer;
    logic             out_xfer;

    // A stage can load when any stage at or beyond it is empty, or the output drains.
    always_comb begin
        free = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!v_q[j]) free[i] = 1'b1;
            end
        end
    end

    assign in_ready  = en && !flush && free[0];
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = v_q[DEPTH-1] && out_ready && en && !flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else if (en) begin
            if (flush) begin
                // Data registers keep stale contents; only validity is cleared.
                v_q     <= '0;
                count_q <= '0;
            end else begin
                if (free[0]) begin
                    v_q[0] <= in_valid;
                    if (in_valid) d_q[0] <= in_data;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (free[i]) begin
                        v_q[i] <= v_q[i-1];
                        if (v_q[i-1]) d_q[i] <= d_q[i-1];
                    end
                end
                case ({in_xfer, out_xfer})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Directed bench for elastic_pipeline_register with DEPTH=3, N=8: reset, latency,
// streaming, backpressure, flush, enable and mid-stream reset scenarios.
module tb_elastic_pipeline_register;

    localparam int N     = 8;
    localparam int DEPTH = 3;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          flush;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    elastic_pipeline_register #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", out_data); else n_pass++;
        n_checks++; if (count !== 2'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_en0 got %b exp 0", in_ready); else n_pass++;
        tick; tick;
        rst_n = 1'b1; en = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_en1 got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_latency;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL lat_in_ready got %b exp 1", in_ready); else n_pass++;
        tick;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || count !== 2'd1) $display("FAIL lat_edge0 got v=%b c=%0d exp v=0 c=1", out_valid, count); else n_pass++;
        tick;
        n_checks++; if (out_valid !== 1'b0 || count !== 2'd1) $display("FAIL lat_edge1 got v=%b c=%0d exp v=0 c=1", out_valid, count); else n_pass++;
        tick;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 2'd1) $display("FAIL lat_edge2 got v=%b d=%h c=%0d exp v=1 d=a5 c=1", out_valid, out_data, count); else n_pass++;
        tick;
        n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL lat_edge3 got v=%b c=%0d exp v=0 c=0", out_valid, count); else n_pass++;
    endtask

    task automatic test_streaming;
        int acc;
        int cons;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 10);
            in_data  = N'(c);
            #1;
            if (c < 10) begin
                n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready c=%0d got %b exp 1", c, in_ready); else n_pass++;
            end
            tick;
            acc  = (c + 1 > 10) ? 10 : c + 1;
            cons = (c >= 3) ? c - 2 : 0;
            n_checks++; if (count !== CW'(acc - cons)) $display("FAIL stream_count c=%0d got %0d exp %0d", c, count, acc - cons); else n_pass++;
            if (c >= 2) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== N'(c - 2)) $display("FAIL stream_out c=%0d got v=%b d=%h exp v=1 d=%h", c, out_valid, out_data, N'(c - 2)); else n_pass++;
            end
        end
        in_valid = 1'b0;
        tick;
        n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL stream_drain got v=%b c=%0d exp v=0 c=0", out_valid, count); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [N-1:0] items [3];
        logic [N-1:0] tail  [2];
        items[0] = 8'h11; items[1] = 8'h22; items[2] = 8'h33;
        tail[0]  = 8'h33; tail[1]  = 8'h44;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = items[i];
            #1;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_accept i=%0d got %b exp 1", i, in_ready); else n_pass++;
            tick;
            n_checks++; if (count !== CW'(i + 1)) $display("FAIL bp_count i=%0d got %0d exp %0d", i, count, i + 1); else n_pass++;
        end
        in_data = 8'h44;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b exp 0", in_ready); else n_pass++;
        tick;
        n_checks++; if (count !== 2'd3 || out_valid !== 1'b1 || out_data !== 8'h11) $display("FAIL bp_held got c=%0d v=%b d=%h exp c=3 v=1 d=11", count, out_valid, out_data); else n_pass++;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_full_passthru got %b exp 1", in_ready); else n_pass++;
        tick;
        in_valid = 1'b0;
        n_checks++; if (count !== 2'd3 || out_data !== 8'h22) $display("FAIL bp_swap got c=%0d d=%h exp c=3 d=22", count, out_data); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick;
            n_checks++; if (out_valid !== 1'b1 || out_data !== tail[i] || count !== CW'(2 - i)) $display("FAIL bp_drain i=%0d got v=%b d=%h c=%0d exp v=1 d=%h c=%0d", i, out_valid, out_data, count, tail[i], 2 - i); else n_pass++;
        end
        tick;
        n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL bp_empty got v=%b c=%0d exp v=0 c=0", out_valid, count); else n_pass++;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55; tick;
        in_data = 8'h66; tick;
        in_valid = 1'b0;
        n_checks++; if (count !== 2'd2) $display("FAIL flush_pre_count got %0d exp 2", count); else n_pass++;
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", in_ready); else n_pass++;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush_clear got c=%0d v=%b exp c=0 v=0", count, out_valid); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL flush_no_accept i=%0d got v=%b c=%0d exp v=0 c=0", i, out_valid, count); else n_pass++;
        end
    endtask

    task automatic test_enable;
        logic [N-1:0] exp_d [4];
        logic         exp_v [4];
        int           exp_c [4];
        exp_v[0] = 1'b0; exp_d[0] = 8'h00; exp_c[0] = 2;
        exp_v[1] = 1'b1; exp_d[1] = 8'h82; exp_c[1] = 2;
        exp_v[2] = 1'b1; exp_d[2] = 8'h83; exp_c[2] = 1;
        exp_v[3] = 1'b0; exp_d[3] = 8'h00; exp_c[3] = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h81; tick;
        in_valid = 1'b0; tick; tick;
        in_valid = 1'b1; in_data = 8'h82; tick;
        n_checks++; if (count !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h81) $display("FAIL en_pre got c=%0d v=%b d=%h exp c=2 v=1 d=81", count, out_valid, out_data); else n_pass++;
        en = 1'b0; in_valid = 1'b1; in_data = 8'h83; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL en_off_ready i=%0d got %b exp 0", i, in_ready); else n_pass++;
            tick;
            n_checks++; if (count !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h81) $display("FAIL en_off_frozen i=%0d got c=%0d v=%b d=%h exp c=2 v=1 d=81", i, count, out_valid, out_data); else n_pass++;
        end
        en = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL en_on_ready got %b exp 1", in_ready); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick;
            in_valid = 1'b0;
            n_checks++; if (out_valid !== exp_v[i] || count !== CW'(exp_c[i]) || (exp_v[i] && out_data !== exp_d[i])) $display("FAIL en_resume i=%0d got v=%b d=%h c=%0d exp v=%b d=%h c=%0d", i, out_valid, out_data, count, exp_v[i], exp_d[i], exp_c[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h99; tick;
        in_valid = 1'b0; tick; tick;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h99 || count !== 2'd1) $display("FAIL mid_pre got v=%b d=%h c=%0d exp v=1 d=99 c=1", out_valid, out_data, count); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== 2'd0) $display("FAIL mid_async got v=%b d=%h c=%0d exp v=0 d=00 c=0", out_valid, out_data, count); else n_pass++;
        #3;
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b exp 1", in_ready); else n_pass++;
        tick;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5A; tick;
        in_valid = 1'b0; tick; tick;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || count !== 2'd1) $display("FAIL mid_post got v=%b d=%h c=%0d exp v=1 d=5a c=1", out_valid, out_data, count); else n_pass++;
        tick;
        n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL mid_post_drain got v=%b c=%0d exp v=0 c=0", out_valid, count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_flush();
        test_enable();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/elastic_pipeline_register.md
# elastic_pipeline_register

Parametrised N-bit, DEPTH-stage pipeline register with valid/ready flow control, clock enable, synchronous flush and an occupancy count. It is the next generation of the team's plain enabled N-bit register. It sits between datapath blocks that need fixed-depth retiming and must also tolerate downstream stalls without losing or duplicating data. Empty stages collapse (bubble removal), so the upstream side can keep filling while the output is stalled.

## Interface
- `N`, default 8: data width in bits; must be ≥1.
- `DEPTH`, default 2: number of register stages; must be ≥1.
- `CW`, default `$clog2(DEPTH+1)`: width of the occupancy output; derived, not overridden.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: clock enable; when 0, no state changes and no transfers occur.
- `flush`, in, 1: synchronous clear of all stage valid bits.
- `in_valid`, in, 1: upstream offers `in_data`.
- `in_data`, in, N: upstream data.
- `in_ready`, out, 1: block accepts `in_data` this cycle.
- `out_valid`, out, 1: `out_data` is valid.
- `out_data`, out, N: data of the last stage.
- `out_ready`, in, 1: downstream accepts `out_data`.
- `count`, out, CW: number of valid stages, 0..DEPTH.

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side): `v[i]` (valid bit) and `d[i]` (N-bit data).
- `out_valid = v[DEPTH-1]`; `out_data = d[DEPTH-1]`. Both are driven directly from registers.
- Free chain (combinational):
  - `free[DEPTH-1] = !v[DEPTH-1] || out_ready`
  - `free[i] = !v[i] || free[i+1]`
- `in_ready = en && !flush && free[0]`.
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready && en && !flush`.
- On each edge with `en=1, flush=0`, every stage i with `free[i]=1` loads from its predecessor:
  - `v[i] <= v[i-1]` and `d[i] <= d[i-1]`.
  - For i=0 the source is the input: `v[0] <= in_valid` and `d[0] <= in_data`.
  - Stages with `free[i]=0` hold their contents.
- `d[i]` is written only when the incoming valid bit is 1. An invalid stage keeps its stale data.
- Flush with `en=1`: all `v[i] <= 0` and `count <= 0`. `d[i]` is unchanged. No input transfer occurs, and any offered output is not consumed (the item is discarded).
- `en=0`: everything holds, including during `flush`. `in_ready=0` and `count` holds.
- `count` is a registered counter:
  - +1 on an input transfer only.
  - −1 on an output transfer only.
  - Unchanged when both or neither occur.
  - Never exceeds DEPTH and never underflows.
- Data order is strictly FIFO. No item is duplicated or dropped except by flush or reset.

## Timing
- Reset (`rst_n=0`, asynchronous): all `v=0`, all `d=0`, `count=0`. Hence `out_valid=0`, `out_data=0`. `in_ready` is high as soon as `en=1`.
- Latency through an empty pipe: an item accepted at edge k is on `out_data` with `out_valid=1` after edge k+DEPTH−1. That is DEPTH cycles from offer to visible output.
- Throughput: 1 item/cycle when `out_ready=1` continuously.
- Full condition: all `v=1` and `out_ready=0`. Then `in_ready=0` in the same cycle and `count=DEPTH`.
- Full with `out_ready=1`: `in_ready=1` through the combinational free chain. A simultaneous in/out transfer leaves `count` unchanged.
- `in_ready` depends combinationally on `out_ready`. The path length is DEPTH stages and is accepted by design.
- Release of `rst_n` mid-stream loses all contents. The first post-reset edge behaves as for an empty pipe.

## Test plan
- Reset: assert `rst_n=0` mid-stream with DEPTH=3 → immediately `out_valid=0`, `out_data=0`, `count=0`. After release, `in_ready=1` with `en=1`.
- Latency: DEPTH=3, empty pipe, offer `in_data=0xA5` for one cycle with `out_ready=1` → `out_valid=1`, `out_data=0xA5` three cycles after the offer, for exactly one cycle. `count` goes 1, 1, 1, 0.
- Streaming: offer 0x00..0x09 back-to-back with `out_ready=1` → outputs 0x00..0x09 on consecutive cycles. `in_ready` never drops and `count` stays at 3 during steady state.
- Backpressure and bubble collapse:
  - Step 1: `out_ready=0`, offer 0x11, 0x22, 0x33, 0x44 → 0x11..0x33 are accepted, `in_ready=0` while 0x44 is held, and `count=3`.
  - Step 2: raise `out_ready` → outputs are 0x11, 0x22, 0x33, 0x44 in order, with no loss.
- Flush: with `count=2`, pulse `flush` while `in_valid=1` → `in_ready=0` that cycle, the next cycle `count=0` and `out_valid=0`, and the offered word is not accepted.
- Enable: hold `en=0` for 5 cycles with the pipe half-full and `in_valid=out_ready=1` → `v`, `d` and `count` are frozen and `in_ready=0`. On re-enable, transfers resume in order.
